// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slot pipeline register with valid/ready, stall and flush.
// Optional feature: define PIPE_SKID_EN to add a skid slot ahead of slot 0.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  load;
    logic [DATA_W-1:0] dat [DEPTH];
    logic              in_fire;
    logic              out_fire;
    logic              src_vld;
    logic [DATA_W-1:0] src_dat;
    logic [CNT_W-1:0]  cnt;

    // A slot may load when it or any slot downstream has a hole,
    // or when the last slot is draining this cycle.
    always_comb begin
        logic acc;
        acc  = out_ready & ~stall;
        load = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc     = acc | ~vld[i];
            load[i] = acc;
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign out_fire  = out_valid & out_ready & ~stall;
    assign in_fire   = in_valid & in_ready;
    assign occupancy = cnt;

`ifdef PIPE_SKID_EN
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;

    assign in_ready = ~skid_vld & ~stall & ~flush;
    assign src_vld  = skid_vld | in_fire;
    assign src_dat  = skid_vld ? skid_dat : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            skid_vld <= 1'b0;
        end else if (!stall) begin
            if (skid_vld && load[0]) begin
                skid_vld <= 1'b0;
            end else if (in_fire && !load[0]) begin
                skid_vld <= 1'b1;
                skid_dat <= in_data;
            end
        end
    end
`else
    assign in_ready = load[0] & ~stall & ~flush;
    assign src_vld  = in_fire;
    assign src_dat  = in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else if (!stall) begin
            if (load[0]) begin
                vld[0] <= src_vld;
                if (src_vld) begin
                    dat[0] <= src_dat;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        dat[i] <= dat[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt
                 + {{(CNT_W-1){1'b0}}, in_fire}
                 - {{(CNT_W-1){1'b0}}, out_fire};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks for pipe_stage_reg at DEPTH 3, 2 and 1.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_st, a_fl, a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_id, a_od;
    logic [3:0]  a_occ;
    logic        b_st, b_fl, b_iv, b_ir, b_ov, b_or;
    logic [31:0] b_id, b_od;
    logic [3:0]  b_occ;
    logic        c_st, c_fl, c_iv, c_ir, c_ov, c_or;
    logic [31:0] c_id, c_od;
    logic [3:0]  c_occ;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(32), .DEPTH(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .stall(a_st), .flush(a_fl),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_or),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .stall(b_st), .flush(b_fl),
        .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_or),
        .occupancy(b_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .DEPTH(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .stall(c_st), .flush(c_fl),
        .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_ready(c_or),
        .occupancy(c_occ)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        reset = 1'b1;
        {a_st, a_fl, a_iv, a_or, a_id} = '0;
        {b_st, b_fl, b_iv, b_or, b_id} = '0;
        {c_st, c_fl, c_iv, c_or, c_id} = '0;
        #2;
        checks++;
        if ({a_ov, a_od, a_occ} !== 37'd0) begin
            errors++;
            $display("FAIL reset_d3 got %h want 0", {a_ov, a_od, a_occ});
        end
        checks++;
        if ({b_ov, b_od, b_occ} !== 37'd0) begin
            errors++;
            $display("FAIL reset_d2 got %h want 0", {b_ov, b_od, b_occ});
        end
        checks++;
        if ({c_ov, c_od, c_occ} !== 37'd0) begin
            errors++;
            $display("FAIL reset_d1 got %h want 0", {c_ov, c_od, c_occ});
        end
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task test_latency;
        logic [31:0] v [3];
        v[0] = 32'h11;
        v[1] = 32'h22;
        v[2] = 32'h33;
        a_or = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_iv = 1'b1;
            a_id = v[k];
            #1;
            checks++;
            if (a_ir !== 1'b1) begin
                errors++;
                $display("FAIL lat_in_ready k=%0d got %b want 1", k, a_ir);
            end
            checks++;
            if (a_ov !== 1'b0) begin
                errors++;
                $display("FAIL lat_early k=%0d got %b want 0", k, a_ov);
            end
            tick;
        end
        a_iv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({a_ov, a_od} !== {1'b1, v[k]}) begin
                errors++;
                $display("FAIL lat_out k=%0d got %b/%h want 1/%h",
                         k, a_ov, a_od, v[k]);
            end
            tick;
        end
        checks++;
        if (a_ov !== 1'b0) begin
            errors++;
            $display("FAIL lat_tail got %b want 0", a_ov);
        end
    endtask

    task test_backpressure;
        logic [31:0] vb [3];
        int idx;
        int got;
        vb[0] = 32'hA1;
        vb[1] = 32'hA2;
        vb[2] = 32'hA3;
        idx = 0;
        got = 0;
        b_or = 1'b0;
        for (int c = 0; c < 5; c++) begin
            b_iv = (idx < 3);
            b_id = (idx < 3) ? vb[idx] : 32'h0;
            #1;
            if (b_iv && b_ir) idx++;
            tick;
        end
        b_iv = (idx < 3);
        b_id = (idx < 3) ? vb[idx] : 32'h0;
        #1;
        checks++;
        if (idx != 2 + SKID) begin
            errors++;
            $display("FAIL bp_accepted got %0d want %0d", idx, 2 + SKID);
        end
        checks++;
        if (b_occ !== 4'(2 + SKID)) begin
            errors++;
            $display("FAIL bp_occ got %0d want %0d", b_occ, 2 + SKID);
        end
        checks++;
        if (b_ir !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 0", b_ir);
        end
        tick;
        b_or = 1'b1;
        for (int c = 0; c < 10; c++) begin
            b_iv = (idx < 3);
            b_id = (idx < 3) ? vb[idx] : 32'h0;
            #1;
            if (b_iv && b_ir) idx++;
            if (b_ov && b_or) begin
                checks++;
                if (got >= 3) begin
                    errors++;
                    $display("FAIL bp_extra got %h want none", b_od);
                end else if (b_od !== vb[got]) begin
                    errors++;
                    $display("FAIL bp_order n=%0d got %h want %h",
                             got, b_od, vb[got]);
                end
                got++;
            end
            tick;
        end
        b_iv = 1'b0;
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_drained got %0d want 3", got);
        end
        checks++;
        if ({b_ov, b_occ} !== 5'd0) begin
            errors++;
            $display("FAIL bp_empty got %b/%0d want 0/0", b_ov, b_occ);
        end
    endtask

    task test_stall;
        b_or = 1'b0;
        b_iv = 1'b1;
        b_id = 32'hB1;
        tick;
        b_id = 32'hB2;
        tick;
        b_st = 1'b1;
        b_or = 1'b1;
        b_id = 32'hB3;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (b_ir !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready c=%0d got %b want 0", c, b_ir);
            end
            checks++;
            if ({b_ov, b_od, b_occ} !== {1'b1, 32'hB1, 4'd2}) begin
                errors++;
                $display("FAIL stall_hold c=%0d got %b/%h/%0d want 1/b1/2",
                         c, b_ov, b_od, b_occ);
            end
            tick;
        end
    endtask

    task test_flush;
        b_fl = 1'b1;
        b_or = 1'b0;
        b_iv = 1'b1;
        b_id = 32'h55;
        #1;
        checks++;
        if (b_ir !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready got %b want 0", b_ir);
        end
        tick;
        b_fl = 1'b0;
        b_st = 1'b0;
        b_iv = 1'b0;
        checks++;
        if ({b_ov, b_occ} !== 5'd0) begin
            errors++;
            $display("FAIL flush_clear got %b/%0d want 0/0", b_ov, b_occ);
        end
        b_or = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (b_ov !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost c=%0d got %b/%h want 0",
                         c, b_ov, b_od);
            end
        end
    endtask

    task test_async_reset;
        b_or = 1'b0;
        b_iv = 1'b1;
        b_id = 32'hC1;
        tick;
        b_id = 32'hC2;
        tick;
        b_iv = 1'b0;
        checks++;
        if (b_occ !== 4'd2) begin
            errors++;
            $display("FAIL ar_fill got %0d want 2", b_occ);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({b_ov, b_od, b_occ} !== 37'd0) begin
            errors++;
            $display("FAIL ar_async got %b/%h/%0d want 0/0/0",
                     b_ov, b_od, b_occ);
        end
        #2;
        reset = 1'b0;
        tick;
        b_or = 1'b1;
        b_iv = 1'b1;
        b_id = 32'h77;
        #1;
        checks++;
        if (b_ir !== 1'b1) begin
            errors++;
            $display("FAIL ar_in_ready got %b want 1", b_ir);
        end
        tick;
        b_iv = 1'b0;
        checks++;
        if (b_ov !== 1'b0) begin
            errors++;
            $display("FAIL ar_early got %b want 0", b_ov);
        end
        tick;
        checks++;
        if ({b_ov, b_od} !== {1'b1, 32'h77}) begin
            errors++;
            $display("FAIL ar_beat got %b/%h want 1/77", b_ov, b_od);
        end
        tick;
        checks++;
        if (b_ov !== 1'b0) begin
            errors++;
            $display("FAIL ar_tail got %b want 0", b_ov);
        end
    endtask

    task test_random;
        logic [31:0] q [$];
        logic [31:0] exp_d;
        logic        pend_v;
        logic [31:0] pend_d;
        pend_v = 1'b0;
        pend_d = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!pend_v) begin
                pend_v = 1'($urandom_range(0, 1));
                pend_d = $urandom;
            end
            c_iv = pend_v;
            c_id = pend_d;
            c_or = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (c_occ !== 4'(q.size())) begin
                errors++;
                $display("FAIL rnd_occ n=%0d got %0d want %0d",
                         n, c_occ, q.size());
            end
            if (c_ov && c_or) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious n=%0d got %h want none",
                             n, c_od);
                end else begin
                    exp_d = q.pop_front();
                    if (c_od !== exp_d) begin
                        errors++;
                        $display("FAIL rnd_data n=%0d got %h want %h",
                                 n, c_od, exp_d);
                    end
                end
            end
            if (c_iv && c_ir) begin
                q.push_back(c_id);
                pend_v = 1'b0;
            end
            tick;
        end
        c_iv = 1'b0;
        c_or = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (c_ov) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_drain_extra got %h want none", c_od);
                end else begin
                    exp_d = q.pop_front();
                    if (c_od !== exp_d) begin
                        errors++;
                        $display("FAIL rnd_drain got %h want %h",
                                 c_od, exp_d);
                    end
                end
            end
            tick;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost got %0d left want 0", q.size());
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_backpressure;
        test_stall;
        test_flush;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
